ex_operand_stage: RTL
=====================

// Module: ex_operand_stage
// PURPOSE
//  Pipeline register and operand-select stage directly upstream of the ALU. It captures a decoded
//  instruction through a valid/ready handshake and holds it across stalls. It resolves RAW hazards by
//  forwarding from MEM and WB, then drives alu_src0 / alu_src1 / alu_op into the combinational ALU.
//  Stored operands snoop WB writes while stalled, so a long stall never yields stale data.
// PARAMETERS
//  XLEN  32  datapath width (operands, imm, pc, forwarded data)
//  OPW   5   alu_op width; must match the ALU op field
//  RAW   5   register address width (32 architectural regs, x0 hardwired zero)
// PORTS
//  clk            in   1     single clock, rising edge
//  rst_n          in   1     asynchronous active-low reset
//  flush          in   1     kill the held instruction (branch redirect/trap)
//  id_valid       in   1     decode presents an instruction
//  id_ready       out  1     stage can accept this cycle
//  id_pc          in   XLEN  instruction pc
//  id_rs1_data    in   XLEN  regfile read, rs1
//  id_rs2_data    in   XLEN  regfile read, rs2
//  id_imm         in   XLEN  sign-extended immediate
//  id_rs1_addr    in   RAW   rs1 index
//  id_rs2_addr    in   RAW   rs2 index
//  id_rd_addr     in   RAW   rd index
//  id_alu_op      in   OPW   ALU operation code
//  id_src0_pc     in   1     1: src0 = pc, 0: src0 = rs1
//  id_src1_imm    in   1     1: src1 = imm, 0: src1 = rs2
//  id_reg_we      in   1     instruction writes rd
//  mem_fwd_we     in   1     MEM stage will write mem_fwd_rd
//  mem_fwd_rd     in   RAW   MEM destination
//  mem_fwd_data   in   XLEN  MEM result
//  wb_fwd_we      in   1     WB writes wb_fwd_rd this cycle
//  wb_fwd_rd      in   RAW   WB destination
//  wb_fwd_data    in   XLEN  WB result
//  ex_valid       out  1     held instruction valid
//  ex_ready       in   1     downstream consumes this cycle
//  alu_src0       out  XLEN  to ALU operand 0
//  alu_src1       out  XLEN  to ALU operand 1
//  alu_op         out  OPW   to ALU op select
//  ex_pc          out  XLEN  held pc
//  ex_rd_addr     out  RAW   held rd
//  ex_reg_we      out  1     held reg_we, gated by ex_valid
// BEHAVIOUR
//  - Reset (async, rst_n=0): ex_valid=0; all held regs 0, so alu_src0=alu_src1=0, alu_op=0, ex_pc=0,
//    ex_rd_addr=0, ex_reg_we=0. Outputs are combinational from regs, so these hold immediately.
//  - id_ready = !ex_valid | ex_ready; fully combinational, no bubble on back-to-back flow.
//  - Load = id_valid & id_ready & !flush. On load, all id_* fields are captured next edge, ex_valid<=1.
//  - Else if ex_valid & ex_ready: ex_valid<=0. Else hold all fields.
//  - flush: ex_valid<=0 next edge; this beats load and a simultaneous id_valid is dropped
//    (decode is also flushed).
//  - Latency: 1 cycle id -> ALU inputs; throughput 1/cycle.
//  - Snoop: while held (no load), if wb_fwd_we & wb_fwd_rd!=0 & wb_fwd_rd==stored rs1 (rs2),
//    stored rs1 (rs2) data <= wb_fwd_data.
//  - Forward (combinational, per operand, on held rsN), priority:
//    1) mem_fwd_we & mem_fwd_rd==rsN & rsN!=0 -> mem_fwd_data
//    2) wb_fwd_we & wb_fwd_rd==rsN & rsN!=0 -> wb_fwd_data
//    3) stored data
//  - x0: a rsN of 0 never forwards and yields the stored value (regfile returns 0).
//  - alu_src0 = src0_pc ? ex_pc : fwd_rs1; alu_src1 = src1_imm ? ex_imm : fwd_rs2.
//  - ex_reg_we = held_reg_we & ex_valid & (ex_rd_addr!=0).
//  - Load-use hazards (MEM result not yet available) are the hazard unit's job and are stalled via
//    id_valid; this stage does not detect them.
// STRUCTURE
//  - Shared package riscv_pkg: XLEN, OPW, RAW localparams; ALU op encodings (shared with ALU).
//  - One sub-module: fwd_mux (rs addr, stored data, mem/wb fwd triplets -> operand); instantiated twice.
//  - Remainder is a flat register bank plus handshake logic.
// TESTING
//  1 Reset: rst_n=0 mid-hold with ex_valid=1 -> ex_valid=0, alu_src0/1=0, alu_op=0 without a clock edge.
//  2 Flow: id_valid=1, ex_ready=1 for 3 cycles (rs1=0xFFFFFFFF, rs2=0x2, op=0..2) -> ex_valid each
//    cycle; ALU inputs match 1 cycle later; id_ready stays 1.
//  3 Stall: ex_ready=0 for 4 cycles with id_valid=1 -> id_ready=0 and outputs stable. Release ->
//    next instruction loads on the following edge.
//  4 Forward: held rs1=5 with stored 0x10; mem_fwd(5,0xAA) and wb_fwd(5,0xBB) together ->
//    alu_src0=0xAA; with MEM only ->0xAA, WB only ->0xBB, rd=0 ->0x10.
//  5 Snoop: stall with rs2=7 stored 0x1; wb_fwd(7,0x55) for one cycle, then idle ->
//    alu_src1 stays 0x55 after WB deasserts.
//  6 Flush: flush=1 with id_valid=1, ex_valid=1 -> ex_valid=0 next cycle, no capture, ex_reg_we=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared datapath widths, ALU op encodings and forwarding helper
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int OPW  = 5;
    localparam int RAW  = 5;

    // ALU operation encodings, shared with the ALU decode
    typedef enum logic [OPW-1:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_SLL  = 5'd2,
        ALU_SLT  = 5'd3,
        ALU_SLTU = 5'd4,
        ALU_XOR  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_OR   = 5'd8,
        ALU_AND  = 5'd9
    } alu_op_e;

    // A producer matches a source register only when it writes, the indices agree,
    // and the source is not x0 (x0 always reads as the regfile's zero).
    function automatic logic fwd_hit(input logic           we,
                                     input logic [RAW-1:0] rd,
                                     input logic [RAW-1:0] rs);
        return we && (rd == rs) && (rs != '0);
    endfunction

endpackage

// File: rtl/ex_operand_stage_if.sv
// rtl/ex_operand_stage_if.sv - decode-to-execute instruction bus with valid/ready handshake
interface ex_operand_stage_if;
    import riscv_pkg::*;

    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [RAW-1:0]  id_rs1_addr;
    logic [RAW-1:0]  id_rs2_addr;
    logic [RAW-1:0]  id_rd_addr;
    logic [OPW-1:0]  id_alu_op;
    logic            id_src0_pc;
    logic            id_src1_imm;
    logic            id_reg_we;

    // decode side drives the instruction, execute side returns ready
    modport master (
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_op,
               id_src0_pc, id_src1_imm, id_reg_we,
        input  id_ready
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_op,
               id_src0_pc, id_src1_imm, id_reg_we,
        output id_ready
    );

endinterface

// File: rtl/ex_operand_stage_fwd_mux.sv
// rtl/ex_operand_stage_fwd_mux.sv - per-operand bypass select, MEM over WB over stored value
module ex_operand_stage_fwd_mux
    import riscv_pkg::*;
(
    input  logic [RAW-1:0]  i_rs_addr,
    input  logic [XLEN-1:0] i_stored,
    input  logic            i_mem_we,
    input  logic [RAW-1:0]  i_mem_rd,
    input  logic [XLEN-1:0] i_mem_data,
    input  logic            i_wb_we,
    input  logic [RAW-1:0]  i_wb_rd,
    input  logic [XLEN-1:0] i_wb_data,
    output logic [XLEN-1:0] o_operand
);

    // the younger MEM result wins over WB; no match falls back to the held value
    always_comb begin
        o_operand = i_stored;
        if (fwd_hit(i_mem_we, i_mem_rd, i_rs_addr)) begin
            o_operand = i_mem_data;
        end else if (fwd_hit(i_wb_we, i_wb_rd, i_rs_addr)) begin
            o_operand = i_wb_data;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX pipeline register with operand forwarding into the ALU
module ex_operand_stage
    import riscv_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_flush,
    ex_operand_stage_if.slave   id_bus,
    input  logic                i_mem_fwd_we,
    input  logic [RAW-1:0]      i_mem_fwd_rd,
    input  logic [XLEN-1:0]     i_mem_fwd_data,
    input  logic                i_wb_fwd_we,
    input  logic [RAW-1:0]      i_wb_fwd_rd,
    input  logic [XLEN-1:0]     i_wb_fwd_data,
    output logic                o_ex_valid,
    input  logic                i_ex_ready,
    output logic [XLEN-1:0]     o_alu_src0,
    output logic [XLEN-1:0]     o_alu_src1,
    output logic [OPW-1:0]      o_alu_op,
    output logic [XLEN-1:0]     o_ex_pc,
    output logic [RAW-1:0]      o_ex_rd_addr,
    output logic                o_ex_reg_we
);

    logic            r_ex_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;
    logic [RAW-1:0]  r_rs1_addr;
    logic [RAW-1:0]  r_rs2_addr;
    logic [RAW-1:0]  r_rd_addr;
    logic [OPW-1:0]  r_alu_op;
    logic            r_src0_pc;
    logic            r_src1_imm;
    logic            r_reg_we;

    logic            w_load;
    logic            w_snoop_rs1;
    logic            w_snoop_rs2;
    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;

    // accept whenever the slot is empty or drains this cycle; flush drops the incoming op
    assign id_bus.id_ready = !r_ex_valid || i_ex_ready;
    assign w_load          = id_bus.id_valid && id_bus.id_ready && !i_flush;

    // a WB write to a held source refreshes the copy so a long stall never goes stale
    assign w_snoop_rs1 = fwd_hit(i_wb_fwd_we, i_wb_fwd_rd, r_rs1_addr);
    assign w_snoop_rs2 = fwd_hit(i_wb_fwd_we, i_wb_fwd_rd, r_rs2_addr);

    // occupancy: flush kills, load fills, consumption empties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid <= 1'b0;
        end else if (i_flush) begin
            r_ex_valid <= 1'b0;
        end else if (w_load) begin
            r_ex_valid <= 1'b1;
        end else if (r_ex_valid && i_ex_ready) begin
            r_ex_valid <= 1'b0;
        end
    end

    // instruction fields: capture on load, otherwise hold while snooping WB into operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1_addr <= '0;
            r_rs2_addr <= '0;
            r_rd_addr  <= '0;
            r_alu_op   <= '0;
            r_src0_pc  <= 1'b0;
            r_src1_imm <= 1'b0;
            r_reg_we   <= 1'b0;
        end else if (w_load) begin
            r_pc       <= id_bus.id_pc;
            r_rs1_data <= id_bus.id_rs1_data;
            r_rs2_data <= id_bus.id_rs2_data;
            r_imm      <= id_bus.id_imm;
            r_rs1_addr <= id_bus.id_rs1_addr;
            r_rs2_addr <= id_bus.id_rs2_addr;
            r_rd_addr  <= id_bus.id_rd_addr;
            r_alu_op   <= id_bus.id_alu_op;
            r_src0_pc  <= id_bus.id_src0_pc;
            r_src1_imm <= id_bus.id_src1_imm;
            r_reg_we   <= id_bus.id_reg_we;
        end else begin
            if (w_snoop_rs1) begin
                r_rs1_data <= i_wb_fwd_data;
            end
            if (w_snoop_rs2) begin
                r_rs2_data <= i_wb_fwd_data;
            end
        end
    end

    ex_operand_stage_fwd_mux u_fwd_rs1 (
        .i_rs_addr  (r_rs1_addr),
        .i_stored   (r_rs1_data),
        .i_mem_we   (i_mem_fwd_we),
        .i_mem_rd   (i_mem_fwd_rd),
        .i_mem_data (i_mem_fwd_data),
        .i_wb_we    (i_wb_fwd_we),
        .i_wb_rd    (i_wb_fwd_rd),
        .i_wb_data  (i_wb_fwd_data),
        .o_operand  (w_fwd_rs1)
    );

    ex_operand_stage_fwd_mux u_fwd_rs2 (
        .i_rs_addr  (r_rs2_addr),
        .i_stored   (r_rs2_data),
        .i_mem_we   (i_mem_fwd_we),
        .i_mem_rd   (i_mem_fwd_rd),
        .i_mem_data (i_mem_fwd_data),
        .i_wb_we    (i_wb_fwd_we),
        .i_wb_rd    (i_wb_fwd_rd),
        .i_wb_data  (i_wb_fwd_data),
        .o_operand  (w_fwd_rs2)
    );

    assign o_ex_valid   = r_ex_valid;
    assign o_alu_src0   = r_src0_pc  ? r_pc  : w_fwd_rs1;
    assign o_alu_src1   = r_src1_imm ? r_imm : w_fwd_rs2;
    assign o_alu_op     = r_alu_op;
    assign o_ex_pc      = r_pc;
    assign o_ex_rd_addr = r_rd_addr;
    assign o_ex_reg_we  = r_reg_we && r_ex_valid && (r_rd_addr != '0);

endmodule
